// File: rtl/pulse_tx.sv
// pulse_tx: stretches single-cycle events into pulses a slower clock domain can sample.
// Ports: clk_src/rst source clock and async active-high reset; pulse_in event strobe;
// ack_in destination acknowledge (used only when USE_ACK=1); clr_ovf clears overflow;
// pulse_out stretched pulse; busy work outstanding; pending queued events; overflow sticky drop.
module pulse_tx #(
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 3,
    parameter int PEND_W      = 4,
    parameter bit USE_ACK     = 1'b0
) (
    input  logic              clk_src,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              ack_in,
    input  logic              clr_ovf,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam int MAX_C = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              pulse_q;
    logic              ack_m_q, ack_s_q;
    logic              pend_nz, h_done, l_done, launch, drop;

    always_comb begin
        pend_nz = |pend_q;
        h_done  = USE_ACK ? ack_s_q : (cnt_q == H_LAST);
        l_done  = USE_ACK ? !ack_s_q : (cnt_q == L_LAST);
        launch  = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE:    launch = pend_nz;
            HIGH:    state_d = h_done ? LOW : HIGH;
            LOW: begin
                launch  = l_done && pend_nz;
                state_d = l_done ? IDLE : LOW;
            end
            default: state_d = IDLE;
        endcase
        if (launch) state_d = HIGH;
        // Counter measures time spent in the current state; it restarts on every entry,
        // including LOW->HIGH back-to-back, and rests at zero while idle.
        cnt_d  = (USE_ACK || state_d != state_q || state_d == IDLE) ? '0 : cnt_q + 1'b1;
        // A launch frees a slot in the same edge, so a full counter still accepts then.
        drop   = pulse_in && !launch && (&pend_q);
        pend_d = (pulse_in && !launch && !drop) ? pend_q + 1'b1 :
                 (launch && !pulse_in)          ? pend_q - 1'b1 : pend_q;
        // Set wins over a same-edge clear.
        ovf_d  = drop || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk_src or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            pulse_q <= (state_d == HIGH);
            ack_m_q <= ack_in;
            ack_s_q <= ack_m_q;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = (state_q != IDLE) || pend_nz;
    assign pending   = pend_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_tx.sv
// tb_pulse_tx: self-checking bench for pulse_tx (default, PEND_W=2 and USE_ACK=1 instances).
module tb_pulse_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    int         checks = 0;
    int         failures = 0;

    logic       d_pi, d_ack, d_clr, d_po, d_busy, d_ovf;
    logic [3:0] d_pend;
    logic       s_pi, s_ack, s_clr, s_po, s_busy, s_ovf;
    logic [1:0] s_pend;
    logic       a_pi, a_ack, a_clr, a_po, a_busy, a_ovf;
    logic [3:0] a_pend;

    pulse_tx u_def (
        .clk_src(clk), .rst(rst), .pulse_in(d_pi), .ack_in(d_ack), .clr_ovf(d_clr),
        .pulse_out(d_po), .busy(d_busy), .pending(d_pend), .overflow(d_ovf)
    );

    pulse_tx #(.PEND_W(2)) u_sat (
        .clk_src(clk), .rst(rst), .pulse_in(s_pi), .ack_in(s_ack), .clr_ovf(s_clr),
        .pulse_out(s_po), .busy(s_busy), .pending(s_pend), .overflow(s_ovf)
    );

    pulse_tx #(.USE_ACK(1'b1)) u_ack (
        .clk_src(clk), .rst(rst), .pulse_in(a_pi), .ack_in(a_ack), .clr_ovf(a_clr),
        .pulse_out(a_po), .busy(a_busy), .pending(a_pend), .overflow(a_ovf)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        {d_pi, d_ack, d_clr, s_pi, s_ack, s_clr, a_pi, a_ack, a_clr} = '0;
        rst = 1'b1;
        #2;
        checks++;
        if ({d_po, d_busy, d_ovf, d_pend} !== 7'd0) begin
            failures++;
            $display("FAIL reset_def: po=%b busy=%b ovf=%b pend=%0d want all 0", d_po, d_busy, d_ovf, d_pend);
        end
        checks++;
        if ({s_po, s_busy, s_ovf, s_pend} !== 5'd0) begin
            failures++;
            $display("FAIL reset_sat: po=%b busy=%b ovf=%b pend=%0d want all 0", s_po, s_busy, s_ovf, s_pend);
        end
        checks++;
        if ({a_po, a_busy, a_ovf, a_pend} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ack: po=%b busy=%b ovf=%b pend=%0d want all 0", a_po, a_busy, a_ovf, a_pend);
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic exp_p, exp_b;
        d_pi = 1'b1;
        tick;
        d_pi = 1'b0;
        checks++;
        if (d_pend !== 4'd1 || d_po !== 1'b0) begin
            failures++;
            $display("FAIL single_accept: pend=%0d po=%b want pend=1 po=0", d_pend, d_po);
        end
        for (int i = 1; i <= 8; i++) begin
            tick;
            exp_p = (i <= 3);
            exp_b = (i < 7);
            checks++;
            if (d_po !== exp_p) begin
                failures++;
                $display("FAIL single_pulse k+%0d: got %b want %b", i, d_po, exp_p);
            end
            checks++;
            if (d_busy !== exp_b) begin
                failures++;
                $display("FAIL single_busy k+%0d: got %b want %b", i, d_busy, exp_b);
            end
        end
        checks++;
        if (d_pend !== 4'd0) begin
            failures++;
            $display("FAIL single_pend_end: got %0d want 0", d_pend);
        end
    endtask

    task automatic test_burst5;
        int   wins, bad_w, bad_g, run, ovf_seen;
        logic prev;
        wins = 0; bad_w = 0; bad_g = 0; run = 0; ovf_seen = 0; prev = 1'b0;
        for (int i = 0; i < 45; i++) begin
            d_pi = (i < 5);
            tick;
            if (d_po != prev) begin
                if (d_po) begin
                    wins++;
                    if (wins > 1 && run != 3) bad_g++;
                end else if (run != 3) bad_w++;
                run = 0;
            end
            run++;
            prev = d_po;
            if (d_ovf) ovf_seen = 1;
        end
        d_pi = 1'b0;
        checks++;
        if (wins != 5) begin
            failures++;
            $display("FAIL burst5_windows: got %0d want 5", wins);
        end
        checks++;
        if (bad_w != 0 || bad_g != 0) begin
            failures++;
            $display("FAIL burst5_shape: bad widths=%0d bad gaps=%0d want 0/0", bad_w, bad_g);
        end
        checks++;
        if (ovf_seen != 0 || d_busy !== 1'b0) begin
            failures++;
            $display("FAIL burst5_ovf_busy: ovf_seen=%0d busy=%b want 0/0", ovf_seen, d_busy);
        end
    endtask

    // Eight back-to-back events: accepted at edges 1-4, dropped at 5-7, and the eighth
    // coincides with the second launch so it is accepted -> five pulses in total.
    task automatic test_sat;
        int   max_p, rises, guard;
        logic prev;
        max_p = 0; rises = 0; guard = 0; prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_pi = 1'b1;
            tick;
            if (int'(s_pend) > max_p) max_p = int'(s_pend);
            if (s_po && !prev) rises++;
            prev = s_po;
        end
        s_pi = 1'b0;
        while (s_busy && guard < 100) begin
            tick;
            guard++;
            if (s_po && !prev) rises++;
            prev = s_po;
        end
        checks++;
        if (s_busy !== 1'b0) begin
            failures++;
            $display("FAIL sat_drain_timeout: busy=%b after %0d cycles want 0", s_busy, guard);
        end
        checks++;
        if (max_p != 3) begin
            failures++;
            $display("FAIL sat_pending_max: got %0d want 3", max_p);
        end
        checks++;
        if (rises != 5) begin
            failures++;
            $display("FAIL sat_pulse_count: got %0d want 5", rises);
        end
        checks++;
        if (s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf_sticky: got %b want 1", s_ovf);
        end
        s_clr = 1'b1;
        tick;
        s_clr = 1'b0;
        checks++;
        if (s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL sat_ovf_clear: got %b want 0", s_ovf);
        end
    endtask

    task automatic test_drop_clr;
        int guard;
        guard = 0;
        s_pi = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        checks++;
        if (s_pend !== 2'd3 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL dropclr_prefill: pend=%0d ovf=%b want 3/0", s_pend, s_ovf);
        end
        s_clr = 1'b1;
        tick;
        s_pi = 1'b0;
        checks++;
        if (s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL dropclr_same_edge: got %b want 1", s_ovf);
        end
        tick;
        s_clr = 1'b0;
        checks++;
        if (s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL dropclr_clear_alone: got %b want 0", s_ovf);
        end
        while (s_busy && guard < 100) begin
            tick;
            guard++;
        end
        checks++;
        if (s_busy !== 1'b0) begin
            failures++;
            $display("FAIL dropclr_drain_timeout: busy=%b want 0", s_busy);
        end
    endtask

    task automatic test_ack;
        int lows;
        lows = 0;
        a_pi = 1'b1;
        tick;
        a_pi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (a_po !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL ack_hold_high: low cycles=%0d want 0", lows);
        end
        a_ack = 1'b1;
        tick;
        tick;
        checks++;
        if (a_po !== 1'b1) begin
            failures++;
            $display("FAIL ack_rise_a+1: po=%b want 1", a_po);
        end
        tick;
        checks++;
        if (a_po !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL ack_rise_a+2: po=%b busy=%b want 0/1", a_po, a_busy);
        end
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (a_po !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL ack_low_hold: po=%b busy=%b want 0/1", a_po, a_busy);
        end
        a_ack = 1'b0;
        tick;
        tick;
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL ack_fall_b+1: busy=%b want 1", a_busy);
        end
        tick;
        checks++;
        if (a_busy !== 1'b0 || a_po !== 1'b0 || a_pend !== 4'd0) begin
            failures++;
            $display("FAIL ack_fall_b+2: busy=%b po=%b pend=%0d want 0/0/0", a_busy, a_po, a_pend);
        end
    endtask

    task automatic test_reset_mid;
        int highs;
        highs = 0;
        d_pi = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        d_pi = 1'b0;
        checks++;
        if (d_pend !== 4'd2 || d_po !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: pend=%0d po=%b want 2/1", d_pend, d_po);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (d_po !== 1'b0 || d_pend !== 4'd0 || d_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: po=%b pend=%0d busy=%b want 0/0/0", d_po, d_pend, d_busy);
        end
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (d_po || d_busy) highs++;
        end
        checks++;
        if (highs != 0) begin
            failures++;
            $display("FAIL rstmid_no_pulse: active cycles=%0d want 0", highs);
        end
    endtask

    // Reference: a pulse launched at edge L occupies the line through edge L+5; a launch
    // happens whenever events are queued and the line is free.
    task automatic test_random;
        int   m_pend, m_last, n, dens, errs;
        logic m_ovf, p, c, launch, drop, e_po, e_busy;
        m_pend = 0; m_last = -100; m_ovf = 1'b0; errs = 0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (n = 0; n < 500; n++) begin
            if (n % 100 == 0) dens = (n / 100 == 0) ? 5 : (n / 100 == 1) ? 70 : (n / 100 == 2) ? 15 : 40;
            p = ($urandom_range(99) < dens);
            c = ($urandom_range(99) < 5);
            d_pi = p;
            d_clr = c;
            d_ack = $urandom_range(1);
            launch = (m_pend > 0) && (n >= m_last + 6);
            drop = p && !launch && (m_pend == 15);
            if (launch) m_last = n;
            if (p && !launch && !drop) m_pend++;
            else if (launch && !p) m_pend--;
            m_ovf = drop || (m_ovf && !c);
            e_po = (n >= m_last) && (n < m_last + 3);
            e_busy = (m_pend > 0) || (n < m_last + 6);
            tick;
            checks++;
            if (d_po !== e_po || d_busy !== e_busy || d_pend !== 4'(m_pend) || d_ovf !== m_ovf) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d: po=%b busy=%b pend=%0d ovf=%b want %b/%b/%0d/%b",
                             n, d_po, d_busy, d_pend, d_ovf, e_po, e_busy, m_pend, m_ovf);
            end
        end
        {d_pi, d_clr, d_ack} = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst5;
        test_sat;
        test_drop_clr;
        test_ack;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
